uart_word_assembler: RTL
========================

// Module: uart_word_assembler
// PURPOSE
//  Sits between the uart_rx byte receiver and the Controller command decoder.
//  Packs received UART bytes MSB-first into WORD_SIZE_BY-byte words and queues them in a BUFFER_SIZE-entry FIFO.
//  The decoder pops words with a valid/ready handshake.
//  An inter-byte timeout discards partial words so a lost byte never misaligns later commands.
// PARAMETERS
//  CLK_FREQ       50000000  system clock in Hz
//  BIT_RATE       115200    UART bit rate; CYCLES_PER_BIT = CLK_FREQ/BIT_RATE (integer division, 434)
//  PAYLOAD_BITS   8         bits per UART byte
//  WORD_SIZE_BY   4         bytes per word; word width W = WORD_SIZE_BY*PAYLOAD_BITS
//  BUFFER_SIZE    8         FIFO depth in words; power of 2, >= 2
//  TIMEOUT_BYTES  4         timeout = TIMEOUT_BYTES*10*CYCLES_PER_BIT cycles (17360 at defaults)
// PORTS
//  clk            in   1                  system clock
//  rst_n          in   1                  asynchronous active-low reset
//  byte_valid_i   in   1                  1-cycle strobe from uart_rx: byte_data_i is valid
//  byte_data_i    in   PAYLOAD_BITS       received byte
//  flush_i        in   1                  synchronous clear of assembler, FIFO and overflow flag
//  word_o         out  W                  FIFO head word; 0 when FIFO is empty
//  word_valid_o   out  1                  FIFO not empty
//  word_ready_i   in   1                  consumer accepts the word; pop when valid & ready
//  fifo_count_o   out  $clog2(BUFFER_SIZE)+1  words currently stored
//  fifo_full_o    out  1                  count == BUFFER_SIZE
//  overflow_o     out  1                  sticky: a completed word was dropped
//  timeout_o      out  1                  1-cycle pulse: a partial word was discarded
// BEHAVIOUR
//  - Reset (async, any time, including mid-word): byte index, shift register, timeout counter and FIFO pointers go to 0.
//    Reset values: word_o=0, word_valid_o=0, fifo_count_o=0, fifo_full_o=0, overflow_o=0, timeout_o=0.
//  - Assembly: the first byte of a word lands in bits [W-1:W-PAYLOAD_BITS]; later bytes fill downward.
//    byte_idx runs 0..WORD_SIZE_BY-1 and wraps to 0 after the last byte.
//  - Push: the last byte's cycle writes the completed word into the FIFO.
//    The word appears at word_o, with word_valid_o=1, on the next clock edge (1-cycle latency when the FIFO was empty).
//  - FIFO ordering is first in, first out; a word is popped on a clock edge where word_valid_o & word_ready_i.
//  - Push into a full FIFO without a pop in the same cycle: the word is dropped, overflow_o is set, and count is unchanged.
//  - Push and pop in the same cycle while full: both take effect, no overflow, count stays BUFFER_SIZE.
//  - Push and pop in the same cycle while empty: the pop is ignored and count becomes 1.
//  - Pointers wrap modulo BUFFER_SIZE; full and empty are both derived from count.
//  - Timeout: the counter clears on every byte_valid_i and counts only while byte_idx != 0.
//    On reaching the threshold: byte_idx and shift register clear, timeout_o pulses 1 cycle, no word is pushed, counter clears.
//    A byte arriving in the threshold cycle wins: the byte is accepted and no timeout fires.
//  - flush_i: byte_idx, FIFO and overflow_o clear on the next edge.
//    flush_i has priority over byte_valid_i and word_ready_i in the same cycle; a byte arriving then is discarded.
//  - Arithmetic: the timeout counter is $clog2(threshold+1) bits wide; count updates as +1, -1 or 0, never both.
// STRUCTURE
//  - controller_pkg: localparams CYCLES_PER_BIT and TIMEOUT_CYCLES; typedef word_t = logic [W-1:0].
//  - Sub-module sync_fifo #(WIDTH, DEPTH): show-ahead FIFO with push, pop, full, empty and count outputs.
//    Reused by the Controller TX path.
//  - Top level holds the assembler shift register, byte index and timeout counter.
// TESTING
//  1. Bytes 00 00 00 70 with ready=1: word_valid_o=1 and word_o=32'h00000070 one cycle after the 4th byte; popped next edge.
//  2. ready=0, send 73 75 6E 67 then 00 00 00 4C: count=2.
//     Then ready=1: pops 32'h73756E67, then 32'h0000004C; count returns to 0.
//  3. Send AA BB, then idle: timeout_o pulses exactly 17360 cycles after BB, no word is pushed.
//     Then 01 02 03 04 yields 32'h01020304.
//  4. ready=0, send 9 words: fifo_full_o=1 after the 8th, the 9th is dropped and overflow_o=1.
//     flush_i then gives count=0 and overflow_o=0.
//  5. FIFO full, ready=1 in the same cycle as the 4th byte: overflow_o stays 0 and count stays 8.
//     Order check: the new word is popped last.
//  6. Drop rst_n after 2 bytes of a word: all outputs reset immediately.
//     After release, DE AD BE EF yields 32'hDEADBEEF with no residue from the partial word.

Source files
------------

// File: rtl/controller_pkg.sv
// Shared constants and types for the controller receive/transmit datapath.
// Default-rate localparams plus a helper so parameterised blocks derive the same values.
package controller_pkg;

    localparam int CLK_FREQ_DEF   = 50000000;
    localparam int BIT_RATE_DEF   = 115200;
    localparam int CYCLES_PER_BIT = CLK_FREQ_DEF / BIT_RATE_DEF;
    localparam int TIMEOUT_CYCLES = 4 * 10 * CYCLES_PER_BIT;
    localparam int WORD_W         = 32;

    typedef logic [WORD_W-1:0] word_t;

    // Inter-byte timeout in clock cycles: tmo_bytes UART frames of 10 bits each.
    function automatic int calc_timeout(input int clk_freq, input int bit_rate, input int tmo_bytes);
        return tmo_bytes * 10 * (clk_freq / bit_rate);
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Show-ahead synchronous FIFO: data_o presents the head entry (0 when empty).
// Full/empty are derived from the occupancy count; pointers wrap modulo DEPTH.
module sync_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     clr_i,
    input  logic                     push_i,
    input  logic [WIDTH-1:0]         data_i,
    input  logic                     pop_i,
    output logic [WIDTH-1:0]         data_o,
    output logic                     full_o,
    output logic                     empty_o,
    output logic [$clog2(DEPTH):0]   count_o
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             empty_s, full_s;
    logic             pop_eff_s, push_eff_s;

    assign empty_s    = (count_q == '0);
    assign full_s     = (count_q == CNT_W'(DEPTH));
    // A pop on an empty FIFO is ignored; a push into a full FIFO only lands if a pop frees a slot.
    assign pop_eff_s  = pop_i & ~empty_s;
    assign push_eff_s = push_i & (~full_s | pop_eff_s);

    assign data_o  = empty_s ? '0 : mem_q[rd_ptr_q];
    assign full_o  = full_s;
    assign empty_o = empty_s;
    assign count_o = count_q;

    // Next-state for pointers and occupancy.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (clr_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push_eff_s) begin
                wr_ptr_d = wr_ptr_q + PTR_W'(1);
            end else begin
                wr_ptr_d = wr_ptr_q;
            end
            if (pop_eff_s) begin
                rd_ptr_d = rd_ptr_q + PTR_W'(1);
            end else begin
                rd_ptr_d = rd_ptr_q;
            end
            case ({push_eff_s, pop_eff_s})
                2'b10:   count_d = count_q + CNT_W'(1);
                2'b01:   count_d = count_q - CNT_W'(1);
                default: count_d = count_q;
            endcase
        end
    end

    // Pointer and occupancy registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage array; contents need no reset since data_o is masked while empty.
    always_ff @(posedge clk) begin
        if (push_eff_s && !clr_i) begin
            mem_q[wr_ptr_q] <= data_i;
        end
    end

endmodule

// File: rtl/uart_word_assembler.sv
// Packs UART bytes MSB-first into words and queues them for the command decoder.
// An inter-byte timeout throws away partial words so later commands stay aligned.
module uart_word_assembler
    import controller_pkg::*;
#(
    parameter int CLK_FREQ      = 50000000,
    parameter int BIT_RATE      = 115200,
    parameter int PAYLOAD_BITS  = 8,
    parameter int WORD_SIZE_BY  = 4,
    parameter int BUFFER_SIZE   = 8,
    parameter int TIMEOUT_BYTES = 4
) (
    input  logic                                   clk,
    input  logic                                   rst_n,
    input  logic                                   byte_valid_i,
    input  logic [PAYLOAD_BITS-1:0]                byte_data_i,
    input  logic                                   flush_i,
    output logic [WORD_SIZE_BY*PAYLOAD_BITS-1:0]   word_o,
    output logic                                   word_valid_o,
    input  logic                                   word_ready_i,
    output logic [$clog2(BUFFER_SIZE):0]           fifo_count_o,
    output logic                                   fifo_full_o,
    output logic                                   overflow_o,
    output logic                                   timeout_o
);

    localparam int W       = WORD_SIZE_BY * PAYLOAD_BITS;
    localparam int IDX_W   = (WORD_SIZE_BY > 1) ? $clog2(WORD_SIZE_BY) : 1;
    localparam int TMO_CYC = calc_timeout(CLK_FREQ, BIT_RATE, TIMEOUT_BYTES);
    localparam int TMO_W   = $clog2(TMO_CYC + 1);

    logic [IDX_W-1:0] idx_q, idx_d;
    logic [W-1:0]     shreg_q, shreg_d;
    logic [TMO_W-1:0] tmo_cnt_q, tmo_cnt_d;
    logic             timeout_q, timeout_d;
    logic             overflow_q, overflow_d;
    logic [W-1:0]     shifted_s;
    logic             last_byte_s;
    logic             push_s;
    logic             fifo_full_s, fifo_empty_s;

    // Earlier bytes move up one slot per new byte, so the first byte ends in the top slot.
    assign shifted_s   = (shreg_q << PAYLOAD_BITS) | W'(byte_data_i);
    assign last_byte_s = (idx_q == IDX_W'(WORD_SIZE_BY - 1));

    // Assembler, timeout and overflow next-state; flush overrides any byte in the same cycle.
    always_comb begin
        idx_d      = idx_q;
        shreg_d    = shreg_q;
        tmo_cnt_d  = tmo_cnt_q;
        timeout_d  = 1'b0;
        overflow_d = overflow_q;
        push_s     = 1'b0;
        if (flush_i) begin
            idx_d      = '0;
            shreg_d    = '0;
            tmo_cnt_d  = '0;
            overflow_d = 1'b0;
        end else if (byte_valid_i) begin
            tmo_cnt_d = '0;
            if (last_byte_s) begin
                push_s  = 1'b1;
                idx_d   = '0;
                shreg_d = '0;
                if (fifo_full_s && !word_ready_i) begin
                    overflow_d = 1'b1;
                end else begin
                    overflow_d = overflow_q;
                end
            end else begin
                idx_d   = idx_q + IDX_W'(1);
                shreg_d = shifted_s;
            end
        end else if (idx_q != '0) begin
            if (tmo_cnt_q == TMO_W'(TMO_CYC - 1)) begin
                idx_d     = '0;
                shreg_d   = '0;
                tmo_cnt_d = '0;
                timeout_d = 1'b1;
            end else begin
                tmo_cnt_d = tmo_cnt_q + TMO_W'(1);
            end
        end else begin
            tmo_cnt_d = '0;
        end
    end

    // Assembler state and status flag registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx_q      <= '0;
            shreg_q    <= '0;
            tmo_cnt_q  <= '0;
            timeout_q  <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            idx_q      <= idx_d;
            shreg_q    <= shreg_d;
            tmo_cnt_q  <= tmo_cnt_d;
            timeout_q  <= timeout_d;
            overflow_q <= overflow_d;
        end
    end

    sync_fifo #(
        .WIDTH (W),
        .DEPTH (BUFFER_SIZE)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .clr_i   (flush_i),
        .push_i  (push_s),
        .data_i  (shifted_s),
        .pop_i   (word_ready_i & ~flush_i),
        .data_o  (word_o),
        .full_o  (fifo_full_s),
        .empty_o (fifo_empty_s),
        .count_o (fifo_count_o)
    );

    assign word_valid_o = ~fifo_empty_s;
    assign fifo_full_o  = fifo_full_s;
    assign overflow_o   = overflow_q;
    assign timeout_o    = timeout_q;

endmodule
